register_tree_sift_up: RTL and testbench

Insertion engine for the register-tree max-heap. It accepts one element per valid/ready handshake and writes it to the next free leaf. It then bubbles the element toward the root, one level per cycle, until the max-heap property holds. This is the enqueue (sift-up) direction of the tree; the existing parent/two-children comparator serves the dequeue (sift-down) direction. The heap contents are exported flat so downstream readers and the sift-down path can observe them.

---
 rtl/heap_pkg.sv | 24 ++
 rtl/sift_up_comparator.sv | 23 ++
 rtl/register_tree_sift_up.sv | 118 +++++++++++
 tb/tb_register_tree_sift_up.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : heap_pkg
// Brief    : Shared types and index helpers for the register-tree max-heap.
// Revision : 1.0
// ============================================================================
package heap_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SIFT = 1'b1
    } heap_state_t;

    function automatic int nodes_of(input int depth);
        return (1 << depth) - 1;
    endfunction

    // Root maps to itself so a stray lookup can never index past the array.
    function automatic int parent_idx(input int i);
        return (i == 0) ? 0 : ((i - 1) >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sift_up_comparator.sv
`default_nettype none
// ============================================================================
// Module   : sift_up_comparator
// Brief    : Child/parent compare-and-exchange for one sift-up step.
// Revision : 1.0
// ============================================================================
module sift_up_comparator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_child,
    input  logic [DATA_WIDTH-1:0] i_parent,
    output logic [DATA_WIDTH-1:0] o_child,
    output logic [DATA_WIDTH-1:0] o_parent,
    output logic                  o_swap
);

    // Strict compare keeps equal keys in insertion order.
    assign o_swap   = i_child > i_parent;
    assign o_child  = o_swap ? i_parent : i_child;
    assign o_parent = o_swap ? i_child  : i_parent;

endmodule
`default_nettype wire

// File: rtl/register_tree_sift_up.sv
`default_nettype none
// ============================================================================
// Module   : register_tree_sift_up
// Brief    : Max-heap insertion engine; writes next leaf, bubbles up 1 level/cycle.
// Revision : 1.0
// ============================================================================
module register_tree_sift_up
    import heap_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TREE_DEPTH = 3,
    localparam int NODES     = nodes_of(TREE_DEPTH),
    localparam int SIZE_W    = $clog2(NODES + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_enq_valid,
    input  logic [DATA_WIDTH-1:0]       i_enq_data,
    output logic                        o_enq_ready,
    output logic [DATA_WIDTH-1:0]       o_top,
    output logic                        o_top_valid,
    output logic [SIZE_W-1:0]           o_size,
    output logic                        o_full,
    output logic                        o_busy,
    output logic [NODES*DATA_WIDTH-1:0] o_heap
);

    localparam int c_CUR_W = (NODES > 1) ? $clog2(NODES) : 1;

    logic [DATA_WIDTH-1:0] r_heap [NODES];
    logic [SIZE_W-1:0]     r_size;
    logic [c_CUR_W-1:0]    r_cursor;
    heap_state_t           r_state;
    heap_state_t           w_state_next;

    logic                  w_full;
    logic                  w_ready;
    logic                  w_accept;
    logic [c_CUR_W-1:0]    w_leaf_idx;
    logic [c_CUR_W-1:0]    w_parent_idx;
    logic [DATA_WIDTH-1:0] w_cmp_child;
    logic [DATA_WIDTH-1:0] w_cmp_parent;
    logic                  w_swap;
    logic                  w_swap_we;

    assign w_full       = (r_size == SIZE_W'(NODES));
    assign w_ready      = (r_state == IDLE) && !w_full;
    assign w_accept     = i_enq_valid && w_ready;
    assign w_leaf_idx   = c_CUR_W'(r_size);
    assign w_parent_idx = c_CUR_W'(parent_idx(int'(r_cursor)));
    assign w_swap_we    = (r_state == SIFT) && w_swap;

    sift_up_comparator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .i_child  (r_heap[r_cursor]),
        .i_parent (r_heap[w_parent_idx]),
        .o_child  (w_cmp_child),
        .o_parent (w_cmp_parent),
        .o_swap   (w_swap)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept && (r_size != '0)) w_state_next = SIFT;
            // Leave once ordered, or on the swap that lands at the root.
            SIFT: if (!w_swap || (w_parent_idx == '0)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_size   <= '0;
            r_cursor <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_size   <= r_size + SIZE_W'(1);
                r_cursor <= w_leaf_idx;
            end else if (w_swap_we) begin
                r_cursor <= w_parent_idx;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NODES; g++) begin : g_node
            localparam logic [c_CUR_W-1:0] c_IDX = c_CUR_W'(g);

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_heap[g] <= '0;
                end else if (w_accept && (w_leaf_idx == c_IDX)) begin
                    r_heap[g] <= i_enq_data;
                end else if (w_swap_we && (r_cursor == c_IDX)) begin
                    r_heap[g] <= w_cmp_child;
                end else if (w_swap_we && (w_parent_idx == c_IDX)) begin
                    r_heap[g] <= w_cmp_parent;
                end
            end

            assign o_heap[g*DATA_WIDTH +: DATA_WIDTH] = r_heap[g];
        end
    endgenerate

    assign o_enq_ready = w_ready;
    assign o_top       = r_heap[0];
    assign o_size      = r_size;
    assign o_full      = w_full;
    assign o_busy      = (r_state == SIFT);
    assign o_top_valid = (r_size != '0) && (r_state != SIFT);

endmodule
`default_nettype wire

// File: tb/tb_register_tree_sift_up.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_tree_sift_up
// Brief    : Directed self-checking bench for the max-heap insertion engine.
// Revision : 1.0
// ============================================================================
module tb_register_tree_sift_up;

    localparam int DATA_WIDTH = 32;
    localparam int TREE_DEPTH = 3;
    localparam int NODES      = 7;
    localparam int SIZE_W     = 3;

    logic                        clk;
    logic                        rst;
    logic                        enq_valid;
    logic [DATA_WIDTH-1:0]       enq_data;
    logic                        enq_ready;
    logic [DATA_WIDTH-1:0]       top;
    logic                        top_valid;
    logic [SIZE_W-1:0]           size;
    logic                        full;
    logic                        busy;
    logic [NODES*DATA_WIDTH-1:0] heap;

    int n_checks = 0;
    int n_pass   = 0;

    register_tree_sift_up #(
        .DATA_WIDTH (DATA_WIDTH),
        .TREE_DEPTH (TREE_DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enq_valid (enq_valid),
        .i_enq_data  (enq_data),
        .o_enq_ready (enq_ready),
        .o_top       (top),
        .o_top_valid (top_valid),
        .o_size      (size),
        .o_full      (full),
        .o_busy      (busy),
        .o_heap      (heap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_heap(input string tag, input logic [31:0] e0, e1, e2, e3, e4, e5, e6);
        logic [NODES*DATA_WIDTH-1:0] exp;
        exp = {e6, e5, e4, e3, e2, e1, e0};
        check_eq(tag, 256'(heap), 256'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enq_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic do_enq(input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        enq_valid = 1'b1;
        enq_data  = d;
        while (!enq_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!enq_ready) check_eq("enq_timeout", 0, 1);
        @(posedge clk);
        #1 enq_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq("idle_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_size"},  256'(size), 0);
        check_eq({tag, "_tv"},    256'(top_valid), 0);
        check_eq({tag, "_rdy"},   256'(enq_ready), 1);
        check_eq({tag, "_busy"},  256'(busy), 0);
        check_eq({tag, "_full"},  256'(full), 0);
        check_eq({tag, "_top"},   256'(top), 0);
        check_heap({tag, "_heap"}, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        enq_valid = 1'b0;
        enq_data = '0;

        // Reset values
        do_reset();
        @(negedge clk);
        check_reset_outputs("rst");

        // 5, 3, 8
        do_enq(32'd5);
        check_eq("a_size1", 256'(size), 1);
        check_eq("a_busy1", 256'(busy), 0);
        check_eq("a_rdy1",  256'(enq_ready), 1);
        do_enq(32'd3);
        check_eq("a_busy2", 256'(busy), 1);
        wait_idle();
        check_heap("a_heap2", 5, 3, 0, 0, 0, 0, 0);
        do_enq(32'd8);
        check_eq("a_leaf8", 256'(heap[2*32 +: 32]), 8);
        check_eq("a_rdy_lo", 256'(enq_ready), 0);
        check_eq("a_tv_lo", 256'(top_valid), 0);
        @(posedge clk); #1;
        check_eq("a_rdy_hi", 256'(enq_ready), 1);
        check_eq("a_busy3", 256'(busy), 0);
        check_heap("a_heap3", 8, 3, 5, 0, 0, 0, 0);
        check_eq("a_top", 256'(top), 8);
        check_eq("a_tv", 256'(top_valid), 1);
        check_eq("a_size3", 256'(size), 3);

        // Ascending 1..7
        do_reset();
        for (int v = 1; v <= 6; v++) begin
            do_enq(32'(v));
            wait_idle();
        end
        check_heap("b_heap6", 6, 4, 5, 1, 3, 2, 0);
        do_enq(32'd7);
        check_heap("b_leaf7", 6, 4, 5, 1, 3, 2, 7);
        @(posedge clk); #1;
        check_heap("b_swap1", 6, 4, 7, 1, 3, 2, 5);
        check_eq("b_busy_mid", 256'(busy), 1);
        @(posedge clk); #1;
        check_heap("b_swap2", 7, 4, 6, 1, 3, 2, 5);
        check_eq("b_busy_end", 256'(busy), 0);
        check_eq("b_top", 256'(top), 7);
        check_eq("b_full", 256'(full), 1);
        check_eq("b_rdy", 256'(enq_ready), 0);
        check_eq("b_size", 256'(size), 7);
        @(negedge clk);
        enq_valid = 1'b1;
        enq_data  = 32'd99;
        repeat (3) @(posedge clk);
        #1 enq_valid = 1'b0;
        check_heap("b_full_heap", 7, 4, 6, 1, 3, 2, 5);
        check_eq("b_full_size", 256'(size), 7);

        // Tie
        do_reset();
        do_enq(32'd4);
        do_enq(32'd4);
        check_eq("c_busy", 256'(busy), 1);
        @(posedge clk); #1;
        check_eq("c_busy_end", 256'(busy), 0);
        check_heap("c_heap", 4, 4, 0, 0, 0, 0, 0);

        // Backpressure during SIFT
        do_reset();
        do_enq(32'd1);
        do_enq(32'd2);
        enq_valid = 1'b1;
        enq_data  = 32'd9;
        @(negedge clk);
        check_eq("d_rdy_lo", 256'(enq_ready), 0);
        check_eq("d_size_hold", 256'(size), 2);
        @(posedge clk); #1;
        check_eq("d_rdy_hi", 256'(enq_ready), 1);
        @(posedge clk); #1;
        enq_valid = 1'b0;
        check_eq("d_size_acc", 256'(size), 3);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check_eq("d_size_once", 256'(size), 3);
        check_heap("d_heap", 9, 1, 2, 0, 0, 0, 0);

        // Reset on the first SIFT edge
        do_reset();
        do_enq(32'd1);
        do_enq(32'd2);
        wait_idle();
        do_enq(32'd9);
        check_eq("e_busy", 256'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("e_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
